// File: rtl/seg7_pkg.sv
// Shared seven-segment constants for the display blocks.
// Segment vectors are {a,b,c,d,e,f,g} with a in bit 6, all active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Indexed by nibble value 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed DIGITS-wide hex display driver with blank gap, per-digit
// blanking/decimal point and frame-coherent load/pending update.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SLOT_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  pending
);

  localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] value_pnd_q, value_act_q;
  logic [DIGITS-1:0]   blank_pnd_q, blank_act_q;
  logic [DIGITS-1:0]   dp_pnd_q, dp_act_q;
  logic                pending_q;

  logic                slot_end, frame_end, dark;
  logic [3:0]          nibble;
  logic [6:0]          seg_dec, seg_d;
  logic [DIGITS-1:0]   an_d;
  logic                dp_d;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);
  assign nibble    = value_act_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  // The first BLANK_CYCLES of every slot keep all anodes off against ghosting.
  assign dark = (32'(cnt_q) < BLANK_CYCLES) || blank_act_q[idx_q];

  always_comb begin
    an_d = '1;
    if (!dark) an_d[idx_q] = 1'b0;
    seg_d = dark ? SEG_OFF : seg_dec;
    dp_d  = dark | ~dp_act_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      value_pnd_q <= '0;
      value_act_q <= '0;
      blank_pnd_q <= '0;
      blank_act_q <= '0;
      dp_pnd_q    <= '0;
      dp_act_q    <= '0;
      pending_q   <= 1'b0;
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
    end else begin
      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (load) begin
        value_pnd_q <= value;
        blank_pnd_q <= blank_mask;
        dp_pnd_q    <= dp_mask;
      end

      // A load in the boundary cycle bypasses the pending stage.
      if (frame_end) begin
        if (load) begin
          value_act_q <= value;
          blank_act_q <= blank_mask;
          dp_act_q    <= dp_mask;
        end else begin
          value_act_q <= value_pnd_q;
          blank_act_q <= blank_pnd_q;
          dp_act_q    <= dp_pnd_q;
        end
        pending_q <= 1'b0;
      end else if (load) begin
        pending_q <= 1'b1;
      end

      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with DIGITS=4, SLOT_CYCLES=4, BLANK_CYCLES=1.
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;

  int n_chk = 0;
  int n_bad = 0;
  // Frame position (idx*4+cnt) that the registered outputs currently reflect.
  int shown;
  logic [15:0] cur;

  seg7_scan_display #(
    .DIGITS       (4),
    .SLOT_CYCLES  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    case (n)
      4'h0: exp_seg = 7'b0000001;  4'h1: exp_seg = 7'b1001111;
      4'h2: exp_seg = 7'b0010010;  4'h3: exp_seg = 7'b0000110;
      4'h4: exp_seg = 7'b1001100;  4'h5: exp_seg = 7'b0100100;
      4'h6: exp_seg = 7'b0100000;  4'h7: exp_seg = 7'b0001111;
      4'h8: exp_seg = 7'b0000000;  4'h9: exp_seg = 7'b0000100;
      4'hA: exp_seg = 7'b0001000;  4'hB: exp_seg = 7'b1100000;
      4'hC: exp_seg = 7'b0110001;  4'hD: exp_seg = 7'b1000010;
      4'hE: exp_seg = 7'b0110000;  default: exp_seg = 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", tag, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    shown = (shown + 1) % 16;
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  // Advance n cycles, checking pins against the given active data.
  task automatic run(input int n, input logic [15:0] v, input logic [3:0] bm,
                     input logic [3:0] dm);
    int ix, ct;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    for (int i = 0; i < n; i++) begin
      tick();
      ix = shown / 4;
      ct = shown % 4;
      if (ct < 1 || bm[ix]) begin
        ea = 4'hF;
        es = 7'h7F;
        ed = 1'b1;
      end else begin
        ea = ~(4'b0001 << ix);
        es = exp_seg(v[4*ix +: 4]);
        ed = ~dm[ix];
      end
      chk("an", 32'(an), 32'(ea));
      chk("seg", 32'(seg), 32'(es));
      chk("dp", 32'(dp), 32'(ed));
    end
  endtask

  task automatic to_boundary(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] dm);
    run(15 - shown, v, bm, dm);
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    value = '0;
    blank_mask = '0;
    dp_mask = '0;
    shown = 15;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_pend", 32'(pending), 32'd0);

    // Basic load, shown from the next frame.
    rst_n = 1'b1;
    load = 1'b1;
    value = 16'h12AF;
    run(1, 16'h0, 4'h0, 4'h0);
    load = 1'b0;
    chk("pend_set", 32'(pending), 32'd1);
    to_boundary(16'h0, 4'h0, 4'h0);
    chk("pend_clr", 32'(pending), 32'd0);
    run(16, 16'h12AF, 4'h0, 4'h0);

    // Two loads mid-frame: newest wins, old frame completes unchanged.
    load = 1'b1;
    value = 16'h0000;
    run(1, 16'h12AF, 4'h0, 4'h0);
    load = 1'b0;
    run(3, 16'h12AF, 4'h0, 4'h0);
    load = 1'b1;
    value = 16'h8888;
    run(1, 16'h12AF, 4'h0, 4'h0);
    load = 1'b0;
    chk("pend_mid", 32'(pending), 32'd1);
    to_boundary(16'h12AF, 4'h0, 4'h0);
    chk("pend_clr2", 32'(pending), 32'd0);
    run(16, 16'h8888, 4'h0, 4'h0);

    // Load in the boundary cycle overrides an earlier pending load.
    load = 1'b1;
    value = 16'h3333;
    run(1, 16'h8888, 4'h0, 4'h0);
    load = 1'b0;
    run(14 - shown, 16'h8888, 4'h0, 4'h0);
    load = 1'b1;
    value = 16'h5555;
    run(1, 16'h8888, 4'h0, 4'h0);
    load = 1'b0;
    chk("pend_bypass", 32'(pending), 32'd0);
    run(16, 16'h5555, 4'h0, 4'h0);

    // Blanking of digit 3 and decimal point on digit 0.
    load = 1'b1;
    value = 16'h4321;
    blank_mask = 4'b1000;
    dp_mask = 4'b0001;
    run(1, 16'h5555, 4'h0, 4'h0);
    load = 1'b0;
    to_boundary(16'h5555, 4'h0, 4'h0);
    run(32, 16'h4321, 4'b1000, 4'b0001);

    // Reset mid-slot discards a pending load.
    load = 1'b1;
    value = 16'h9999;
    blank_mask = 4'h0;
    dp_mask = 4'hF;
    run(1, 16'h4321, 4'b1000, 4'b0001);
    load = 1'b0;
    run(5, 16'h4321, 4'b1000, 4'b0001);
    chk("pend_pre_rst", 32'(pending), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_an", 32'(an), 32'hF);
    chk("mrst_seg", 32'(seg), 32'h7F);
    chk("mrst_dp", 32'(dp), 32'd1);
    chk("mrst_pend", 32'(pending), 32'd0);
    rst_n = 1'b1;
    dp_mask = 4'h0;
    shown = 15;
    run(32, 16'h0, 4'h0, 4'h0);

    // Sweep every nibble on digit 0.
    cur = 16'h0;
    for (int i = 0; i < 16; i++) begin
      load = 1'b1;
      value = 16'(i);
      run(1, cur, 4'h0, 4'h0);
      load = 1'b0;
      to_boundary(cur, 4'h0, 4'h0);
      cur = 16'(i);
      run(16, cur, 4'h0, 4'h0);
    end
    run(160, cur, 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
